// File: rtl/regfile_dbg_ctrl.sv
// Debug-side register file client: halts the core, reads/writes/dumps
// registers for the host, and passes core writeback through when idle.
module regfile_dbg_ctrl #(
  parameter int HALT_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_addr,
  input  logic [4:0]  cmd_count,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_addr,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        core_halt,
  input  logic        core_halted,
  input  logic        core_wen,
  input  logic [4:0]  core_waddr,
  input  logic [31:0] core_wdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ACCESS,
    RSP,
    RELEASE
  } state_t;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  state_t           state;
  logic [1:0]       op;
  logic [4:0]       addr;
  logic [4:0]       end_addr;
  logic [31:0]      wdata;
  logic [CNT_W-1:0] cnt;

  logic [5:0]       dump_end;
  logic             illegal;
  logic             dbg_wr;
  logic             is_last;

  assign cmd_ready = (state == IDLE);
  assign dump_end  = {1'b0, cmd_addr} + {1'b0, cmd_count};
  assign illegal   = (cmd_op == OP_RSV) ||
                     ((cmd_op == OP_DUMP) && (dump_end > 6'd31));
  assign dbg_wr    = (state == ACCESS) && (op == OP_WR);
  assign is_last   = (op != OP_DUMP) || (addr == end_addr);
  assign rf_raddr  = addr;

  // Write port: debug write owns it in ACCESS, core otherwise
  always_comb begin
    rf_wen   = core_wen;
    rf_waddr = core_waddr;
    rf_wdata = core_wdata;
    if (dbg_wr) begin
      rf_wen   = (addr != 5'd0);
      rf_waddr = addr;
      rf_wdata = wdata;
    end
  end

  // Command sequencer with registered halt and response outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      op        <= OP_RD;
      addr      <= 5'd0;
      end_addr  <= 5'd0;
      wdata     <= 32'd0;
      cnt       <= '0;
      core_halt <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_addr  <= 5'd0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op       <= cmd_op;
            addr     <= cmd_addr;
            end_addr <= dump_end[4:0];
            wdata    <= cmd_wdata;
            cnt      <= '0;
            if (illegal) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_last  <= 1'b1;
              rsp_data  <= 32'd0;
              rsp_addr  <= cmd_addr;
            end else begin
              state     <= HALT;
              core_halt <= 1'b1;
            end
          end
        end
        HALT: begin
          if (core_halted) begin
            state <= ACCESS;
            cnt   <= '0;
          end else if (cnt == CNT_W'(HALT_TIMEOUT - 1)) begin
            state     <= RSP;
            cnt       <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_data  <= 32'd0;
            rsp_addr  <= addr;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACCESS: begin
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_addr  <= addr;
          rsp_err   <= 1'b0;
          rsp_last  <= is_last;
          if (op == OP_WR) begin
            rsp_data <= (addr == 5'd0) ? 32'd0 : wdata;
          end else begin
            rsp_data <= rf_rdata;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if ((op == OP_DUMP) && !rsp_last) begin
              addr  <= addr + 5'd1;
              state <= ACCESS;
            end else if (core_halt) begin
              core_halt <= 1'b0;
              state     <= RELEASE;
            end else begin
              state <= IDLE;
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Self-checking bench for regfile_dbg_ctrl: vector tables, directed
// corner sequences and random commands against a register-level model.
module tb_regfile_dbg_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [4:0]  cmd_count;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_addr;
  logic        rsp_last;
  logic        rsp_err;
  logic        core_halt;
  logic        core_halted;
  logic        core_wen;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;

  always #5 clk = ~clk;

  regfile_dbg_ctrl #(
    .HALT_TIMEOUT(TO),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_count(cmd_count),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_addr(rsp_addr),
    .rsp_last(rsp_last),
    .rsp_err(rsp_err),
    .core_halt(core_halt),
    .core_halted(core_halted),
    .core_wen(core_wen),
    .core_waddr(core_waddr),
    .core_wdata(core_wdata),
    .rf_wen(rf_wen),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata)
  );

  // Register file and core stall model
  logic [31:0] mem [32];
  logic [31:0] ref_rf [32];
  int          cyc = 0;
  int          dbg_wr_cnt = 0;
  int          halt_cyc = 0;
  logic [4:0]  last_dbg_waddr = 5'd0;
  logic [31:0] last_dbg_wdata = 32'd0;
  int          halt_mode = 0;
  logic        halt_q = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : mem[rf_raddr];
  assign core_halted = (halt_mode == 0) ? 1'b1 :
                       ((halt_mode == 1) ? halt_q : 1'b0);

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    halt_q <= core_halt;
    if (rf_wen && rf_waddr != 5'd0) mem[rf_waddr] <= rf_wdata;
    if (rf_wen && !core_wen) begin
      dbg_wr_cnt     <= dbg_wr_cnt + 1;
      last_dbg_waddr <= rf_waddr;
      last_dbg_wdata <= rf_wdata;
    end
    if (core_halt) halt_cyc <= halt_cyc + 1;
  end

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic        l;
    logic        e;
  } rsp_t;

  typedef struct {
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
  } pt_vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  a;
    logic [4:0]  c;
    logic [31:0] wd;
    int          stall;
    int          mode;
    int          e_nrsp;
    logic        e_err;
  } cmd_vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [4:0] a,
                         input logic [4:0] c, input logic [31:0] wd,
                         input int stall, input int mode,
                         output int nrsp, output logic got_err);
    rsp_t        exp_q[$];
    rsp_t        r;
    logic        illegal;
    logic        tmo;
    logic        dbg_write;
    int          h;
    int          lat;
    int          n;
    int          w0;
    int          hc0;
    logic [31:0] held;
    illegal = (op == 2'b11) || (op == 2'b10 && (int'(a) + int'(c) > 31));
    tmo = !illegal && (mode == 2);
    dbg_write = (op == 2'b01) && !illegal && !tmo && (a != 5'd0);
    nrsp = 0;
    got_err = 1'b0;
    if (illegal || tmo) begin
      r.d = 32'd0; r.a = a; r.l = 1'b1; r.e = 1'b1;
      exp_q.push_back(r);
    end else if (op == 2'b00) begin
      r.d = ref_rf[a]; r.a = a; r.l = 1'b1; r.e = 1'b0;
      exp_q.push_back(r);
    end else if (op == 2'b01) begin
      r.d = (a == 5'd0) ? 32'd0 : wd; r.a = a; r.l = 1'b1; r.e = 1'b0;
      exp_q.push_back(r);
    end else begin
      for (int i = 0; i <= int'(c); i++) begin
        r.a = 5'(int'(a) + i);
        r.d = ref_rf[r.a];
        r.l = (i == int'(c));
        r.e = 1'b0;
        exp_q.push_back(r);
      end
    end
    halt_mode = mode;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    w0 = dbg_wr_cnt;
    hc0 = halt_cyc;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_count = c;
    cmd_wdata = wd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    h = cyc;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (!rsp_valid) begin
        chk("rsp_wait", 32'(rsp_valid), 32'd1);
        break;
      end
      if (nrsp == 0) begin
        lat = cyc - h;
        if (illegal) chk("lat_illegal", 32'(lat), 32'd0);
        else if (tmo) chk("lat_timeout", 32'(lat >= TO && lat <= TO + 1), 32'd1);
        else if (mode == 0) chk("lat_first", 32'(lat), 32'd2);
      end
      nrsp++;
      got_err = got_err | rsp_err;
      if (!r.e || illegal) chk("rsp_data", rsp_data, r.d);
      if (!r.e) chk("rsp_addr", 32'(rsp_addr), 32'(r.a));
      chk("rsp_last", 32'(rsp_last), 32'(r.l));
      chk("rsp_err", 32'(rsp_err), 32'(r.e));
      held = rsp_data;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_data", rsp_data, held);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("back_to_idle", 32'(cmd_ready), 32'd1);
    chk("halt_released", 32'(core_halt), 32'd0);
    chk("dbg_wr_count", 32'(dbg_wr_cnt - w0), dbg_write ? 32'd1 : 32'd0);
    if (dbg_write) begin
      chk("dbg_waddr", 32'(last_dbg_waddr), 32'(a));
      chk("dbg_wdata", last_dbg_wdata, wd);
    end
    if (illegal) chk("no_halt", 32'(halt_cyc - hc0), 32'd0);
    if (dbg_write) ref_rf[a] = wd;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pt_vec_t     pt[4];
    cmd_vec_t    tbl[10];
    int          nr;
    logic        ge;
    int          n;
    logic [1:0]  rop;
    logic [4:0]  ra;
    logic [4:0]  rc;
    int          rm;
    int          k;

    pt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
    pt[1] = '{1'b0, 5'd9,  32'h00000001, 1'b0, 5'd9,  32'h00000001, 1'b1};
    pt[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
    pt[3] = '{1'b1, 5'd0,  32'h00000055, 1'b1, 5'd0,  32'h00000055, 1'b1};

    tbl[0] = '{2'b01, 5'd7,  5'd0,  32'h12345678, 0, 0, 1,  1'b0};
    tbl[1] = '{2'b00, 5'd7,  5'd0,  32'h0,        4, 0, 1,  1'b0};
    tbl[2] = '{2'b10, 5'd30, 5'd1,  32'h0,        1, 0, 2,  1'b0};
    tbl[3] = '{2'b10, 5'd31, 5'd1,  32'h0,        0, 0, 1,  1'b1};
    tbl[4] = '{2'b11, 5'd3,  5'd0,  32'h0,        2, 0, 1,  1'b1};
    tbl[5] = '{2'b00, 5'd5,  5'd0,  32'h0,        0, 2, 1,  1'b1};
    tbl[6] = '{2'b01, 5'd0,  5'd0,  32'hCAFEF00D, 0, 0, 1,  1'b0};
    tbl[7] = '{2'b00, 5'd0,  5'd0,  32'h0,        0, 1, 1,  1'b0};
    tbl[8] = '{2'b01, 5'd3,  5'd0,  32'hA5A5F00F, 1, 1, 1,  1'b0};
    tbl[9] = '{2'b10, 5'd0,  5'd31, 32'h0,        0, 1, 32, 1'b0};

    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_addr = 5'd0;
    cmd_count = 5'd0;
    cmd_wdata = 32'd0;
    rsp_ready = 1'b0;
    core_wen = 1'b0;
    core_waddr = 5'd0;
    core_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_core_halt", 32'(core_halt), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      core_wen = pt[i].wen;
      core_waddr = pt[i].wa;
      core_wdata = pt[i].wd;
      @(negedge clk);
      chk("pt_wen", 32'(rf_wen), 32'(pt[i].e_wen));
      chk("pt_waddr", 32'(rf_waddr), 32'(pt[i].e_wa));
      chk("pt_wdata", rf_wdata, pt[i].e_wd);
      chk("pt_ready", 32'(cmd_ready), 32'(pt[i].e_rdy));
      if (pt[i].wen && pt[i].wa != 5'd0) ref_rf[pt[i].wa] = pt[i].wd;
    end

    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      core_wen = 1'b1;
      core_waddr = 5'(i);
      core_wdata = $urandom;
      ref_rf[i] = core_wdata;
    end
    @(negedge clk);
    core_wen = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].op, tbl[i].a, tbl[i].c, tbl[i].wd,
              tbl[i].stall, tbl[i].mode, nr, ge);
      chk("tbl_nrsp", 32'(nr), 32'(tbl[i].e_nrsp));
      chk("tbl_err", 32'(ge), 32'(tbl[i].e_err));
    end

    halt_mode = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_addr = 5'd0;
    cmd_count = 5'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rsp_seen", 32'(rsp_valid), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_halt", 32'(core_halt), 32'd0);
    chk("mid_rst_idle", 32'(cmd_ready), 32'd1);
    run_cmd(2'b00, 5'd2, 5'd0, 32'd0, 1, 0, nr, ge);
    chk("post_rst_nrsp", 32'(nr), 32'd1);

    for (int it = 0; it < 40; it++) begin
      k = $urandom % 3;
      for (int j = 0; j < k; j++) begin
        @(negedge clk);
        core_wen = 1'($urandom % 2);
        core_waddr = 5'($urandom % 32);
        core_wdata = $urandom;
        if (core_wen && core_waddr != 5'd0) ref_rf[core_waddr] = core_wdata;
      end
      @(negedge clk);
      core_wen = 1'b0;
      rop = 2'($urandom % 4);
      ra = 5'($urandom % 32);
      rc = 5'($urandom % 8);
      rm = $urandom % 8;
      rm = (rm == 0) ? 2 : ((rm < 4) ? 1 : 0);
      run_cmd(rop, ra, rc, $urandom, $urandom % 3, rm, nr, ge);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
